// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension, writeback source select,
// load fault detection and a retired-instruction counter feeding the register file.
`timescale 1ns/1ps
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             reg_write_in,
  input  logic [4:0]       rd_in,
  input  logic [1:0]       wb_sel_in,
  input  logic [2:0]       funct3_in,
  input  logic [1:0]       addr_lo_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [XLEN-1:0]  pc4_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [XLEN-1:0]  mem_rdata_in,
  output logic             RegWrite,
  output logic [4:0]       Wt_addr,
  output logic [XLEN-1:0]  Wt_data,
  output logic             wb_valid,
  output logic             load_fault,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_valid;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic [1:0]       r_wb_sel;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [XLEN-1:0]  r_alu;
  logic [XLEN-1:0]  r_pc4;
  logic [XLEN-1:0]  r_imm;
  logic [XLEN-1:0]  r_rdata;
  logic [CNT_W-1:0] r_instret;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_load_data;
  logic             w_misalign;
  logic             w_illegal;
  logic             w_load_fault;
  logic [XLEN-1:0]  w_wb_data;

  // Flush beats stall; the instruction currently held still retires unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= '0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_alu       <= '0;
      r_pc4       <= '0;
      r_imm       <= '0;
      r_rdata     <= '0;
      r_instret   <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (!stall) begin
        r_valid     <= valid_in;
        r_reg_write <= reg_write_in;
        r_rd        <= rd_in;
        r_wb_sel    <= wb_sel_in;
        r_funct3    <= funct3_in;
        r_addr_lo   <= addr_lo_in;
        r_alu       <= alu_result_in;
        r_pc4       <= pc4_in;
        r_imm       <= imm_in;
        r_rdata     <= mem_rdata_in;
      end
      if (r_valid && !stall && !w_load_fault)
        r_instret <= r_instret + CNT_ONE;
    end
  end

  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_addr_lo)
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      2'd3:    w_byte = r_rdata[31:24];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_addr_lo[1] ? r_rdata[31:16] : r_rdata[15:0];
  end

  always_comb begin
    w_load_data = '0;
    w_misalign  = 1'b0;
    w_illegal   = 1'b0;
    case (r_funct3)
      F3_LB:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
        w_misalign  = r_addr_lo[0];
      end
      F3_LHU: begin
        w_load_data = {{(XLEN-16){1'b0}}, w_half};
        w_misalign  = r_addr_lo[0];
      end
      F3_LW: begin
        w_load_data = r_rdata;
        w_misalign  = |r_addr_lo;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_load_fault = r_valid & (r_wb_sel == SEL_LOAD) & (w_illegal | w_misalign);

  always_comb begin
    w_wb_data = r_alu;
    case (r_wb_sel)
      SEL_ALU:  w_wb_data = r_alu;
      SEL_LOAD: w_wb_data = w_load_data;
      SEL_PC4:  w_wb_data = r_pc4;
      SEL_IMM:  w_wb_data = r_imm;
      default:  w_wb_data = r_alu;
    endcase
  end

  assign Wt_data    = w_load_fault ? '0 : w_wb_data;
  assign RegWrite   = r_valid & r_reg_write & (|r_rd) & ~w_load_fault;
  assign Wt_addr    = r_valid ? r_rd : 5'd0;
  assign wb_valid   = r_valid;
  assign load_fault = w_load_fault;
  assign instret    = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors plus random traffic, with
// expected writebacks queued at issue and checked by an independent monitor.
`timescale 1ns/1ps
module tb_mem_wb_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] rdata;
  } stim_t;

  typedef struct packed {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic             clk, rst_n, stall, flush, valid_in, reg_write_in;
  logic [4:0]       rd_in;
  logic [1:0]       wb_sel_in, addr_lo_in;
  logic [2:0]       funct3_in;
  logic [XLEN-1:0]  alu_result_in, pc4_in, imm_in, mem_rdata_in;
  logic             RegWrite, wb_valid, load_fault;
  logic [4:0]       Wt_addr;
  logic [XLEN-1:0]  Wt_data;
  logic [CNT_W-1:0] instret;

  mem_wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .rd_in(rd_in), .wb_sel_in(wb_sel_in),
    .funct3_in(funct3_in), .addr_lo_in(addr_lo_in), .alu_result_in(alu_result_in),
    .pc4_in(pc4_in), .imm_in(imm_in), .mem_rdata_in(mem_rdata_in),
    .RegWrite(RegWrite), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .wb_valid(wb_valid),
    .load_fault(load_fault), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  exp_t sb[$];
  exp_t e_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: decode the load by size/signedness and extract with shifts and masks.
  function automatic exp_t model(input stim_t s);
    exp_t            e;
    longint unsigned val, mask;
    int              nbytes;
    bit              flt;
    flt = 0;
    val = 0;
    case (s.sel)
      2'd0: val = s.alu;
      2'd2: val = s.pc4;
      2'd3: val = s.imm;
      default: begin
        if (s.f3 == 3'd3 || s.f3 == 3'd6 || s.f3 == 3'd7) flt = 1;
        else begin
          nbytes = 1 << s.f3[1:0];
          if ((int'(s.lo) % nbytes) != 0) flt = 1;
          mask = (64'd1 << (8 * nbytes)) - 64'd1;
          val  = (longint'(s.rdata) >> (8 * int'(s.lo))) & mask;
          if (!s.f3[2] && val[8*nbytes-1]) val = val | ~mask;
        end
      end
    endcase
    e.fault = flt;
    e.data  = flt ? 32'd0 : val[31:0];
    e.rw    = s.rw && (s.rd != 5'd0) && !flt;
    e.addr  = s.rd;
    return e;
  endfunction

  function automatic stim_t mk(input logic v, input logic rw, input logic [4:0] rd,
                               input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                               input logic [31:0] alu, input logic [31:0] rdata);
    stim_t s;
    s.v = v; s.rw = rw; s.rd = rd; s.sel = sel; s.f3 = f3; s.lo = lo;
    s.alu = alu; s.pc4 = 32'h104; s.imm = 32'hABCDE000; s.rdata = rdata;
    return s;
  endfunction

  function automatic exp_t ex(input logic rw, input logic [4:0] a, input logic [31:0] d, input logic f);
    exp_t e;
    e.rw = rw; e.addr = a; e.data = d; e.fault = f;
    return e;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.v = ($urandom_range(0, 4) != 0); s.rw = $urandom_range(0, 1);
    s.rd = 5'($urandom); s.sel = 2'($urandom); s.f3 = 3'($urandom); s.lo = 2'($urandom);
    s.alu = $urandom; s.pc4 = $urandom; s.imm = $urandom; s.rdata = $urandom;
    return s;
  endfunction

  // Called at posedge+1: drive for the coming edge, queue expectation if captured.
  task automatic apply(input stim_t s, input bit st, input bit fl, input bit use_e, input exp_t e);
    valid_in = s.v; reg_write_in = s.rw; rd_in = s.rd; wb_sel_in = s.sel;
    funct3_in = s.f3; addr_lo_in = s.lo; alu_result_in = s.alu; pc4_in = s.pc4;
    imm_in = s.imm; mem_rdata_in = s.rdata; stall = st; flush = fl;
    if (s.v && !st && !fl) sb.push_back(use_e ? e : model(s));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("instret", 64'(instret), 64'(exp_cnt % (1 << CNT_W)));
      if (wb_valid) begin
        if (sb.size() == 0) chk("unexpected_valid", 64'(wb_valid), 64'd0);
        else begin
          e_m = sb[0];
          chk("RegWrite", 64'(RegWrite), 64'(e_m.rw));
          chk("Wt_addr", 64'(Wt_addr), 64'(e_m.addr));
          chk("Wt_data", 64'(Wt_data), 64'(e_m.data));
          chk("load_fault", 64'(load_fault), 64'(e_m.fault));
          if (!stall) begin
            if (!e_m.fault) exp_cnt++;
            void'(sb.pop_front());
          end else if (flush) void'(sb.pop_front());
        end
      end else begin
        chk("idle_RegWrite", 64'(RegWrite), 64'd0);
        chk("idle_Wt_addr", 64'(Wt_addr), 64'd0);
        chk("idle_load_fault", 64'(load_fault), 64'd0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_RegWrite"}, 64'(RegWrite), 64'd0);
    chk({tag, "_Wt_addr"}, 64'(Wt_addr), 64'd0);
    chk({tag, "_Wt_data"}, 64'(Wt_data), 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_load_fault"}, 64'(load_fault), 64'd0);
    chk({tag, "_instret"}, 64'(instret), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] RD = 32'h80F07F81;
  stim_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    stall = 0; flush = 0; valid_in = 1; reg_write_in = 1; rd_in = 5'd3; wb_sel_in = 2'd0;
    funct3_in = 0; addr_lo_in = 0; alu_result_in = 32'hDEAD; pc4_in = 32'h8;
    imm_in = 32'h1000; mem_rdata_in = RD;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    apply(mk(1, 1, 5, 0, 0, 0, 32'h1234, RD), 0, 0, 1, ex(1, 5, 32'h00001234, 0));

    apply(mk(1, 1, 10, 1, 3'b000, 0, 0, RD), 0, 0, 1, ex(1, 10, 32'hFFFFFF81, 0));
    apply(mk(1, 1, 10, 1, 3'b100, 0, 0, RD), 0, 0, 1, ex(1, 10, 32'h00000081, 0));
    apply(mk(1, 1, 11, 1, 3'b000, 1, 0, RD), 0, 0, 1, ex(1, 11, 32'h0000007F, 0));
    apply(mk(1, 1, 12, 1, 3'b001, 2, 0, RD), 0, 0, 1, ex(1, 12, 32'hFFFF80F0, 0));
    apply(mk(1, 1, 13, 1, 3'b101, 2, 0, RD), 0, 0, 1, ex(1, 13, 32'h000080F0, 0));
    apply(mk(1, 1, 14, 1, 3'b010, 0, 0, RD), 0, 0, 1, ex(1, 14, 32'h80F07F81, 0));
    apply(mk(1, 1, 15, 1, 3'b010, 2, 0, RD), 0, 0, 1, ex(0, 15, 32'h0, 1));
    apply(mk(1, 1, 16, 1, 3'b001, 1, 0, RD), 0, 0, 1, ex(0, 16, 32'h0, 1));
    apply(mk(1, 1, 17, 1, 3'b011, 0, 0, RD), 0, 0, 1, ex(0, 17, 32'h0, 1));
    apply(mk(1, 1, 18, 2, 0, 0, 0, RD), 0, 0, 1, ex(1, 18, 32'h00000104, 0));
    apply(mk(1, 1, 19, 3, 0, 0, 0, RD), 0, 0, 1, ex(1, 19, 32'hABCDE000, 0));
    apply(mk(1, 1, 0, 0, 0, 0, 32'h55, RD), 0, 0, 1, ex(0, 0, 32'h00000055, 0));

    apply(mk(1, 1, 7, 0, 0, 0, 32'h77, RD), 0, 0, 1, ex(1, 7, 32'h77, 0));
    repeat (3) apply(rnd(), 1, 0, 0, '0);
    apply(idle, 0, 0, 0, '0);

    apply(mk(1, 1, 9, 0, 0, 0, 32'h99, RD), 0, 0, 1, ex(1, 9, 32'h99, 0));
    apply(mk(1, 1, 8, 0, 0, 0, 32'h88, RD), 1, 1, 0, '0);
    chk("flush_stall_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_stall_RegWrite", 64'(RegWrite), 64'd0);

    repeat (400) apply(rnd(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), 0, '0);
    repeat (2) apply(idle, 0, 0, 0, '0);

    apply(mk(1, 1, 6, 0, 0, 0, 32'h66, RD), 0, 0, 1, ex(1, 6, 32'h66, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    exp_cnt  = 0;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (17) apply(mk(1, 1, 1, 0, 0, 0, $urandom, RD), 0, 0, 0, '0);
    repeat (2) apply(idle, 0, 0, 0, '0);
    chk("instret_wrap", 64'(instret), 64'd1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage RV32I core. Sits directly upstream of the register file and drives its RegWrite, Wt_addr and Wt_data ports.
- Captures MEM-stage results, then aligns and sign/zero-extends load data and selects the writeback source.
- Flags faulting loads and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 64, width of instret counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold stage contents this cycle
- flush  in  1  replace incoming instruction with bubble
- valid_in  in  1  MEM stage holds a real instruction
- reg_write_in  in  1  instruction writes rd
- rd_in  in  5  destination register
- wb_sel_in  in  2  00 ALU, 01 load, 10 PC+4, 11 imm
- funct3_in  in  3  load type
- addr_lo_in  in  2  load address bits [1:0]
- alu_result_in  in  XLEN  ALU result
- pc4_in  in  XLEN  PC+4
- imm_in  in  XLEN  immediate (LUI)
- mem_rdata_in  in  XLEN  raw aligned memory word
- RegWrite  out  1  regfile write enable
- Wt_addr  out  5  regfile write address
- Wt_data  out  XLEN  regfile write data
- wb_valid  out  1  stage holds a valid instruction (forwarding unit)
- load_fault  out  1  current instruction is a misaligned or illegal load
- instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst_n low, async):
  - All stage registers clear; valid=0.
  - Outputs: RegWrite=0, Wt_addr=0, Wt_data=0, wb_valid=0, load_fault=0, instret=0.
- Capture on each rising edge, with priority flush > stall > load:
  - flush: valid register <= 0; other fields don't-care.
  - stall (no flush): all registers hold.
  - Otherwise: all *_in fields are registered.
- Latency: one cycle, input to outputs. All outputs are combinational from registered state only; there is no input-to-output combinational path.
- Load extraction (wb_sel=01), byte lane = addr_lo:
  - LB 000: sign-extend byte mem_rdata[8*lo+7:8*lo].
  - LBU 100: same byte, zero-extended.
  - LH 001 / LHU 101: halfword at bits [16*lo[1]+15:16*lo[1]], sign- or zero-extended. Requires lo[0]=0.
  - LW 010: full word. Requires lo=00.
  - funct3 011, 110, 111 are illegal.
- load_fault = valid & wb_sel==01 & (illegal funct3 | misaligned).
- Wt_data:
  - Selected per wb_sel.
  - Forced to 0 when load_fault=1.
- RegWrite = valid & reg_write & (rd!=0) & !load_fault.
- Wt_addr = registered rd while valid, else 0.
- wb_valid = valid register.
- instret:
  - Increments by 1 on each rising edge where valid=1, stall=0 and load_fault=0.
  - Wraps modulo 2^CNT_W.
  - Faulting or stalled cycles do not count, so a stalled instruction counts exactly once.
- Stall while valid: outputs stay constant. RegWrite is re-asserted each stalled cycle; re-writing the same value is harmless to the regfile.
- Flush and stall together: bubble is loaded; flush wins.
- Reset deassertion mid-stream: the first capture occurs at the first rising edge after rst_n goes high.

Test Plan:
- Reset: rst_n=0 with active inputs -> all outputs 0. Release rst_n and present ALU op rd=5, alu=0x1234 -> next cycle RegWrite=1, Wt_addr=5, Wt_data=0x00001234, instret becomes 1 at the following edge.
- Load extraction, mem_rdata=0x80F0_7F81:
  - LB lo=0 -> 0xFFFFFF81.
  - LBU lo=0 -> 0x00000081.
  - LB lo=1 -> 0x0000007F.
  - LH lo=2 -> 0xFFFF80F0.
  - LHU lo=2 -> 0x000080F0.
  - LW lo=0 -> 0x80F07F81.
- Faults:
  - LW lo=2 -> load_fault=1, RegWrite=0, Wt_data=0, instret unchanged.
  - LH lo=1 -> same response.
  - funct3=011 lo=0 -> same response.
- Sources, pc4=0x104, imm=0xABCDE000:
  - wb_sel=10 -> Wt_data=0x104.
  - wb_sel=11 -> Wt_data=0xABCDE000.
  - rd=0 with reg_write=1 -> RegWrite=0, instret still increments.
- Pipeline control:
  - Stall 3 cycles while holding rd=7 -> outputs constant, instret +1 total.
  - flush=1 together with stall=1 -> wb_valid=0 and RegWrite=0 next cycle.
  - Async reset asserted mid-cycle -> outputs clear immediately, before the next edge.
- Counter wrap: CNT_W=4, retire 17 valid instructions -> instret=1.
